sd_cmd: RTL and testbench

- Host-side SD CMD-line controller. It serialises a 48-bit command frame with CRC7 onto the CMD line, waits for the card response, and deserialises it.
- Checks the response CRC7 and reports done, timeout or CRC error to the upstream SD control FSM.
- Sits directly under ghost_sd, between the SD controller FSM and the iocmd_sd pad. The tristate buffer lives in the top level; this block supplies data and output enable.

---
 rtl/sd_cmd_pkg.sv | 22 ++
 rtl/sd_cmd_if.sv | 25 ++
 rtl/sd_crc7.sv | 27 ++
 rtl/sd_cmd.sv | 212 +++++++++++++++++++++
 tb/tb_sd_cmd.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared SD CMD-line definitions (package sd_defs)
package sd_defs;

   localparam int FRAME_48  = 48;
   localparam int FRAME_136 = 136;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_48   = 2'd1;
   localparam logic [1:0] RESP_136  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX,
      ST_WAIT,
      ST_RX,
      ST_TRAIL,
      ST_DONE
   } sd_state_t;

endpackage

// File: rtl/sd_cmd_if.sv
// rtl/sd_cmd_if.sv - command request/result bundle between SD control FSM and sd_cmd
interface sd_cmd_if;

   logic         istart;
   logic [5:0]   icmd_index;
   logic [31:0]  icmd_arg;
   logic [1:0]   iresp_type;
   logic         obusy;
   logic         odone;
   logic         oerr_timeout;
   logic         oerr_crc;
   logic [5:0]   oresp_index;
   logic [119:0] oresp;

   modport master (
      output istart, icmd_index, icmd_arg, iresp_type,
      input  obusy, odone, oerr_timeout, oerr_crc, oresp_index, oresp
   );

   modport slave (
      input  istart, icmd_index, icmd_arg, iresp_type,
      output obusy, odone, oerr_timeout, oerr_crc, oresp_index, oresp
   );

endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1), MSB-first, shared by CMD and DAT paths
module sd_crc7
   import sd_defs::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       enable,
   input  logic       din,
   output logic [6:0] crc
);

   logic fb;

   assign fb = din ^ crc[6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (enable) begin
         crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
      end
   end

endmodule

// File: rtl/sd_cmd.sv
// rtl/sd_cmd.sv - SD CMD-line controller: command serialiser, response deserialiser, CRC7 check
module sd_cmd
   import sd_defs::*;
#(
   parameter int TIMEOUT = 64,
   parameter int NCC     = 8
) (
   input  logic      iclk,
   input  logic      irst_n,
   input  logic      ifall,
   input  logic      irise,
   input  logic      icmd_sd,
   output logic      ocmd_sd,
   output logic      ocmd_oe,
   sd_cmd_if.slave   bus
);

   localparam logic [7:0] LAST_48  = 8'(FRAME_48 - 1);
   localparam logic [7:0] LAST_136 = 8'(FRAME_136 - 1);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0] NCC_LAST = 8'(NCC - 1);

   sd_state_t    state, state_n;
   logic [39:0]  tx_sr;
   logic [134:0] rx_sr;
   logic [135:0] rx_next;
   logic [7:0]   cnt;
   logic         has_resp;
   logic         is_r2;
   logic         released;
   logic         err_timeout;
   logic         err_crc;
   logic [119:0] resp;
   logic [5:0]   resp_index;

   logic         accept;
   logic         rx_last;
   logic         crc_ok;
   logic         crc_clr;
   logic         crc_en;
   logic         crc_din;
   logic [6:0]   crc;
   logic         unused_bits;

   sd_crc7 u_crc (
      .clk    (iclk),
      .rst_n  (irst_n),
      .clear  (crc_clr),
      .enable (crc_en),
      .din    (crc_din),
      .crc    (crc)
   );

   assign accept      = bus.istart && (state == ST_IDLE || state == ST_DONE);
   assign rx_next     = {rx_sr, icmd_sd};
   assign rx_last     = is_r2 ? (cnt == LAST_136) : (cnt == LAST_48);
   assign crc_ok      = (crc == rx_next[7:1]) && icmd_sd;
   assign unused_bits = ^rx_next[135:134];

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      crc_clr = 1'b0;
      crc_en  = 1'b0;
      crc_din = icmd_sd;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_n = ST_TX;
               crc_clr = 1'b1;
            end
         end
         ST_TX: begin
            if (ifall) begin
               if (cnt >= 8'd8) begin
                  crc_en  = 1'b1;
                  crc_din = tx_sr[39];
               end
               if (cnt == 8'd0) state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ifall && !released && !has_resp) begin
               state_n = ST_TRAIL;
            end else if (irise && released) begin
               if (!icmd_sd) begin
                  state_n = ST_RX;
                  crc_clr = 1'b1;
               end else if (cnt == TMO_LAST) begin
                  state_n = ST_TRAIL;
               end
            end
         end
         ST_RX: begin
            if (irise) begin
               // R2 CRC skips the 8-bit header; R1-style covers everything before the CRC
               crc_en = is_r2 ? (cnt >= 8'd8 && cnt <= 8'd127) : (cnt <= 8'd39);
               if (rx_last) state_n = ST_TRAIL;
            end
         end
         ST_TRAIL: begin
            if (ifall && cnt == NCC_LAST) state_n = ST_DONE;
         end
         ST_DONE: begin
            state_n = accept ? ST_TX : ST_IDLE;
            crc_clr = accept;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         tx_sr       <= '0;
         rx_sr       <= '0;
         cnt         <= '0;
         has_resp    <= 1'b0;
         is_r2       <= 1'b0;
         released    <= 1'b0;
         err_timeout <= 1'b0;
         err_crc     <= 1'b0;
         resp        <= '0;
         resp_index  <= '0;
         ocmd_sd     <= 1'b1;
         ocmd_oe     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  tx_sr       <= {2'b01, bus.icmd_index, bus.icmd_arg};
                  has_resp    <= (bus.iresp_type != RESP_NONE);
                  is_r2       <= (bus.iresp_type == RESP_136);
                  cnt         <= LAST_48;
                  released    <= 1'b0;
                  err_timeout <= 1'b0;
                  err_crc     <= 1'b0;
               end
            end
            ST_TX: begin
               if (ifall) begin
                  ocmd_oe <= 1'b1;
                  if (cnt >= 8'd8) begin
                     ocmd_sd <= tx_sr[39];
                     tx_sr   <= {tx_sr[38:0], 1'b0};
                  end else if (cnt != 8'd0) begin
                     ocmd_sd <= crc[cnt[2:0] - 3'd1];
                  end else begin
                     ocmd_sd <= 1'b1;
                  end
                  cnt <= (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
               end
            end
            ST_WAIT: begin
               if (ifall && !released) begin
                  ocmd_oe  <= 1'b0;
                  ocmd_sd  <= 1'b1;
                  released <= 1'b1;
               end
               if (irise && released) begin
                  if (!icmd_sd) begin
                     cnt   <= 8'd1;
                     rx_sr <= rx_next[134:0];
                  end else if (cnt == TMO_LAST) begin
                     err_timeout <= 1'b1;
                     cnt         <= 8'd0;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end
            ST_RX: begin
               if (irise) begin
                  rx_sr <= rx_next[134:0];
                  if (rx_last) begin
                     cnt     <= 8'd0;
                     err_crc <= !crc_ok;
                     if (is_r2) begin
                        resp       <= rx_next[127:8];
                        resp_index <= rx_next[133:128];
                     end else begin
                        resp       <= {88'd0, rx_next[39:8]};
                        resp_index <= rx_next[45:40];
                     end
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end
            ST_TRAIL: begin
               if (ifall) cnt <= cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.obusy        = (state == ST_TX) || (state == ST_WAIT) ||
                             (state == ST_RX) || (state == ST_TRAIL);
   assign bus.odone        = (state == ST_DONE);
   assign bus.oerr_timeout = err_timeout;
   assign bus.oerr_crc     = err_crc;
   assign bus.oresp_index  = resp_index;
   assign bus.oresp        = resp;

endmodule

// File: tb/tb_sd_cmd.sv
// tb/tb_sd_cmd.sv - self-checking bench for sd_cmd with strobe generator and SD card model
module tb_sd_cmd;
   import sd_defs::*;

   localparam int TMO = 64;
   localparam int NCC_CLK = 8;

   logic iclk = 1'b0;
   logic irst_n = 1'b0;
   logic ifall = 1'b0;
   logic irise = 1'b0;
   logic icmd_sd = 1'b1;
   logic ocmd_sd;
   logic ocmd_oe;

   sd_cmd_if bus ();

   sd_cmd #(.TIMEOUT(TMO), .NCC(NCC_CLK)) dut (
      .iclk    (iclk),
      .irst_n  (irst_n),
      .ifall   (ifall),
      .irise   (irise),
      .icmd_sd (icmd_sd),
      .ocmd_sd (ocmd_sd),
      .ocmd_oe (ocmd_oe),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;

   logic tx_q[$];
   logic card_q[$];
   int   oe_rises = 0;
   int   idle_rises = 0;
   int   card_wait = 0;
   int   card_delay = 0;
   bit   card_on = 0;
   bit   card_active = 0;
   int   done_pulses = 0;
   logic [47:0]  tx_val;
   logic [119:0] exp_oresp;

   initial forever #5 iclk = ~iclk;

   // SD clock = iclk/4; card samples CMD at rise and drives its response on fall
   initial begin : gen
      int ph;
      ph = 0;
      forever begin
         @(negedge iclk);
         ph = (ph + 1) % 4;
         irise = (ph == 0);
         ifall = (ph == 2);
         if (irise) begin
            if (ocmd_oe === 1'b1) begin
               tx_q.push_back(ocmd_sd);
               oe_rises++;
               if (oe_rises == 48 && card_on) card_wait = card_delay;
            end else if (oe_rises == 48) begin
               idle_rises++;
            end
         end
         if (ifall && card_wait > 0) begin
            card_wait--;
            if (card_wait == 0) card_active = 1;
         end
         if (ifall && card_active) begin
            if (card_q.size() > 0) icmd_sd = card_q.pop_front();
            else begin
               icmd_sd = 1'b1;
               card_active = 0;
            end
         end
      end
   end

   initial forever begin
      @(posedge iclk);
      #2;
      if (bus.odone === 1'b1) done_pulses++;
   end

   task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // remainder of M(x)*x^7 divided by x^7+x^3+1 (long division, zero-augmented)
   function automatic logic [6:0] crc7_model(input logic [135:0] msg, input int n);
      logic [6:0] r;
      logic b, top;
      r = '0;
      for (int j = 0; j < n + 7; j++) begin
         b = (j < n) ? msg[n - 1 - j] : 1'b0;
         top = r[6];
         r = {r[5:0], b};
         if (top) r = r ^ 7'h09;
      end
      return r;
   endfunction

   function automatic logic [47:0] frame48(input logic [5:0] idx, input logic [31:0] arg);
      logic [135:0] m;
      m = {96'd0, 2'b01, idx, arg};
      return {2'b01, idx, arg, crc7_model(m, 40), 1'b1};
   endfunction

   function automatic logic [47:0] r1_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [135:0] m;
      m = {96'd0, 2'b00, idx, arg};
      return {2'b00, idx, arg, crc7_model(m, 40), 1'b1};
   endfunction

   function automatic logic [135:0] r2_frame(input logic [119:0] cid);
      logic [135:0] m;
      m = {16'd0, cid};
      return {8'h3F, cid, crc7_model(m, 120), 1'b1};
   endfunction

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                          input logic [135:0] resp, input int resp_len, input int delay,
                          input bit mid_start);
      bit ok;
      tx_q.delete();
      card_q.delete();
      oe_rises = 0;
      idle_rises = 0;
      card_wait = 0;
      card_active = 0;
      card_on = (resp_len > 0);
      card_delay = delay;
      for (int i = resp_len - 1; i >= 0; i--) card_q.push_back(resp[i]);
      @(posedge iclk); #1;
      bus.istart = 1'b1;
      bus.icmd_index = idx;
      bus.icmd_arg = arg;
      bus.iresp_type = rtype;
      @(posedge iclk); #1;
      bus.istart = 1'b0;
      chk("busy_after_start", {135'd0, bus.obusy}, 136'd1);
      ok = 0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge iclk); #1;
         if (mid_start && c == 400) begin
            bus.istart = 1'b1;
            bus.icmd_index = 6'h11;
            bus.iresp_type = RESP_NONE;
         end else begin
            bus.istart = 1'b0;
         end
         if (bus.odone === 1'b1) begin
            ok = 1;
            break;
         end
      end
      bus.istart = 1'b0;
      chk("done_seen", {135'd0, ok}, 136'd1);
      chk("busy_low_at_done", {135'd0, bus.obusy}, 136'd0);
      tx_val = '0;
      foreach (tx_q[i]) tx_val = {tx_val[46:0], tx_q[i]};
      chk("tx_bits", 136'(oe_rises), 136'd48);
      chk("tx_frame", {88'd0, tx_val}, {88'd0, frame48(idx, arg)});
   endtask

   initial begin : main
      logic [135:0] resp;
      logic [127:0] rnd;
      logic [119:0] cid;
      logic [1:0]   rtype;
      logic [5:0]   ridx, cidx;
      logic [31:0]  rarg, carg;
      int           rlen, k, dpre;
      bit           bad, reached;

      bus.istart = 1'b0;
      bus.icmd_index = '0;
      bus.icmd_arg = '0;
      bus.iresp_type = '0;
      exp_oresp = '0;

      repeat (5) @(posedge iclk);
      #1;
      chk("rst_cmd_sd", {135'd0, ocmd_sd}, 136'd1);
      chk("rst_cmd_oe", {135'd0, ocmd_oe}, 136'd0);
      chk("rst_busy", {135'd0, bus.obusy}, 136'd0);
      chk("rst_done", {135'd0, bus.odone}, 136'd0);
      chk("rst_errs", {134'd0, bus.oerr_timeout, bus.oerr_crc}, 136'd0);
      chk("rst_resp", {16'd0, bus.oresp_index, bus.oresp}, 136'd0);
      irst_n = 1'b1;

      // CMD0, no response
      run_cmd(6'd0, 32'h0, RESP_NONE, '0, 0, 0, 0);
      chk("cmd0_frame_const", {88'd0, tx_val}, {88'd0, 48'h400000000095});
      chk("cmd0_idle_clocks", 136'(idle_rises), 136'(NCC_CLK));
      chk("cmd0_errs", {134'd0, bus.oerr_timeout, bus.oerr_crc}, 136'd0);

      // CMD8 with good R7
      run_cmd(6'd8, 32'h1AA, RESP_48, {88'd0, 48'h08000001AA13}, 48, 5, 0);
      chk("cmd8_frame_const", {88'd0, tx_val}, {88'd0, 48'h48000001AA87});
      chk("cmd8_index", {130'd0, bus.oresp_index}, 136'd8);
      chk("cmd8_resp", {16'd0, bus.oresp}, 136'h1AA);
      chk("cmd8_errs", {134'd0, bus.oerr_timeout, bus.oerr_crc}, 136'd0);
      exp_oresp = 120'h1AA;

      // CMD8 with corrupted CRC byte
      run_cmd(6'd8, 32'h1AA, RESP_48, {88'd0, 48'h08000001AA15}, 48, 5, 0);
      chk("badcrc_flag", {135'd0, bus.oerr_crc}, 136'd1);
      chk("badcrc_tmo", {135'd0, bus.oerr_timeout}, 136'd0);
      chk("badcrc_resp", {16'd0, bus.oresp}, 136'h1AA);

      // CMD8 with no card
      run_cmd(6'd8, 32'h1AA, RESP_48, '0, 0, 0, 0);
      chk("tmo_flag", {135'd0, bus.oerr_timeout}, 136'd1);
      chk("tmo_crc", {135'd0, bus.oerr_crc}, 136'd0);
      chk("tmo_idle_clocks", 136'(idle_rises), 136'(TMO + NCC_CLK - 1));
      chk("tmo_resp_kept", {16'd0, bus.oresp}, {16'd0, exp_oresp});

      // CMD2 with R2, istart mid-transfer ignored
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      cid = rnd[119:0];
      run_cmd(6'd2, 32'h0, RESP_136, r2_frame(cid), 136, $urandom_range(8, 2), 1);
      chk("r2_resp", {16'd0, bus.oresp}, {16'd0, cid});
      chk("r2_index", {130'd0, bus.oresp_index}, 136'h3F);
      chk("r2_errs", {134'd0, bus.oerr_timeout, bus.oerr_crc}, 136'd0);
      exp_oresp = cid;
      repeat (20) @(posedge iclk);
      #1;
      chk("r2_no_restart", {135'd0, bus.obusy}, 136'd0);

      // randomized commands against the reference model
      for (int n = 0; n < 8; n++) begin
         rtype = 2'($urandom_range(3, 0));
         cidx = 6'($urandom());
         carg = $urandom();
         ridx = 6'($urandom());
         rarg = $urandom();
         bad = 1'($urandom_range(1, 0));
         rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
         cid = rnd[119:0];
         if (rtype == RESP_NONE) begin
            resp = '0;
            rlen = 0;
         end else if (rtype == RESP_136) begin
            resp = r2_frame(cid);
            rlen = 136;
         end else begin
            resp = {88'd0, r1_frame(ridx, rarg)};
            rlen = 48;
         end
         if (bad && rlen > 0) begin
            k = $urandom_range(7, 0);
            resp[k] = ~resp[k];
         end
         run_cmd(cidx, carg, rtype, resp, rlen, $urandom_range(20, 2), 0);
         chk("rnd_tmo", {135'd0, bus.oerr_timeout}, 136'd0);
         if (rlen == 0) begin
            chk("rnd_none_crc", {135'd0, bus.oerr_crc}, 136'd0);
            chk("rnd_none_resp", {16'd0, bus.oresp}, {16'd0, exp_oresp});
         end else begin
            if (rlen == 136) exp_oresp = cid;
            else exp_oresp = {88'd0, rarg};
            chk("rnd_crc", {135'd0, bus.oerr_crc}, {135'd0, bad});
            chk("rnd_resp", {16'd0, bus.oresp}, {16'd0, exp_oresp});
            chk("rnd_index", {130'd0, bus.oresp_index}, {130'd0, (rlen == 136) ? 6'h3F : ridx});
         end
      end

      // reset in the middle of TX
      tx_q.delete();
      oe_rises = 0;
      card_on = 0;
      card_q.delete();
      @(posedge iclk); #1;
      bus.istart = 1'b1;
      bus.icmd_index = 6'd17;
      bus.icmd_arg = $urandom();
      bus.iresp_type = RESP_48;
      @(posedge iclk); #1;
      bus.istart = 1'b0;
      reached = 0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge iclk); #1;
         if (oe_rises >= 20) begin
            reached = 1;
            break;
         end
      end
      chk("abort_reached_bit20", {135'd0, reached}, 136'd1);
      dpre = done_pulses;
      irst_n = 1'b0;
      #1;
      chk("abort_oe", {135'd0, ocmd_oe}, 136'd0);
      chk("abort_busy", {135'd0, bus.obusy}, 136'd0);
      chk("abort_cmd_sd", {135'd0, ocmd_sd}, 136'd1);
      repeat (10) @(posedge iclk);
      #1;
      irst_n = 1'b1;
      repeat (200) @(posedge iclk);
      #3;
      chk("abort_no_done", 136'(done_pulses), 136'(dpre));
      chk("abort_resp_cleared", {16'd0, bus.oresp}, 136'd0);

      run_cmd(6'd0, 32'h0, RESP_NONE, '0, 0, 0, 0);
      chk("post_abort_frame", {88'd0, tx_val}, {88'd0, 48'h400000000095});
      chk("post_abort_errs", {134'd0, bus.oerr_timeout, bus.oerr_crc}, 136'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
